// File: rtl/r_fifo_word_packer.sv
// r_fifo_word_packer: drains bytes from the r_fifo read port and packs
// them little-endian into words; FLUSH emits a zero-padded partial word.
module r_fifo_word_packer #(
  parameter int BYTES_PER_WORD = 4,
  parameter int NB_W           = 3
) (
  input  logic                        CLOCK,
  input  logic                        RESET,
  input  logic [7:0]                  FIFO_Q,
  input  logic                        FIFO_EMPTY,
  output logic                        FIFO_RE,
  output logic [8*BYTES_PER_WORD-1:0] OUT_DATA,
  output logic [NB_W-1:0]             OUT_NBYTES,
  output logic                        OUT_VALID,
  input  logic                        OUT_READY,
  input  logic                        FLUSH,
  output logic                        BUSY
);

  localparam int DW = 8 * BYTES_PER_WORD;
  localparam logic [NB_W-1:0] FULL = NB_W'(BYTES_PER_WORD);
  localparam logic [NB_W:0] FULL_X = (NB_W+1)'(BYTES_PER_WORD);

  typedef enum logic [1:0] {
    RUN,
    FLUSH_WAIT,
    FLUSH_EMIT
  } state_t;

  state_t          state_q;
  logic            busy_q;
  logic [DW-1:0]   acc_q;
  logic [DW-1:0]   acc_d;
  logic [NB_W-1:0] acc_cnt_q;
  logic            rd_pend_q;
  logic [DW-1:0]   out_data_q;
  logic [NB_W-1:0] out_nb_q;
  logic            out_valid_q;

  logic            out_free;
  logic [NB_W:0]   fill;
  logic            word_full;
  logic            load_full;
  logic            emit;
  logic            wait_done;
  logic            run_re;
  logic [DW-1:0]   part_word;

  assign out_free  = ~out_valid_q | OUT_READY;
  // Byte count the accumulator will hold once the in-flight byte lands.
  assign fill      = {1'b0, acc_cnt_q} + (NB_W+1)'(rd_pend_q);
  assign word_full = (fill == FULL_X);
  assign load_full = word_full & out_free;
  assign emit      = (state_q == FLUSH_EMIT) & out_free;
  assign wait_done = ~rd_pend_q & (acc_cnt_q != FULL);

  // The last lane may only be read ahead if its word can leave this edge.
  assign run_re = ~FIFO_EMPTY &
                  ((fill < FULL_X) |
                   (word_full & rd_pend_q & out_free));

  assign FIFO_RE = ~RESET & (state_q == RUN) & run_re;

  // Merge the arriving byte into its lane and build the padded partial word.
  always_comb begin
    acc_d     = acc_q;
    part_word = '0;
    for (int i = 0; i < BYTES_PER_WORD; i++) begin
      if (rd_pend_q && (acc_cnt_q == NB_W'(i))) begin
        acc_d[8*i +: 8] = FIFO_Q;
      end
      if (NB_W'(i) < acc_cnt_q) begin
        part_word[8*i +: 8] = acc_q[8*i +: 8];
      end
    end
  end

  // Accumulator, read tracking and output word register.
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      acc_q       <= '0;
      acc_cnt_q   <= '0;
      rd_pend_q   <= 1'b0;
      out_data_q  <= '0;
      out_nb_q    <= '0;
      out_valid_q <= 1'b0;
    end else begin
      rd_pend_q <= FIFO_RE;
      acc_q     <= acc_d;
      if (load_full || emit) begin
        acc_cnt_q <= '0;
      end else begin
        acc_cnt_q <= fill[NB_W-1:0];
      end
      if (load_full) begin
        out_data_q  <= acc_d;
        out_nb_q    <= FULL;
        out_valid_q <= 1'b1;
      end else if (emit) begin
        out_data_q  <= part_word;
        out_nb_q    <= acc_cnt_q;
        out_valid_q <= 1'b1;
      end else if (OUT_READY) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  // Flush sequencing with registered BUSY.
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      state_q <= RUN;
      busy_q  <= 1'b0;
    end else begin
      unique case (state_q)
        RUN: begin
          if (FLUSH) begin
            state_q <= FLUSH_WAIT;
            busy_q  <= 1'b1;
          end
        end
        FLUSH_WAIT: begin
          if (wait_done) begin
            if (acc_cnt_q == '0) begin
              state_q <= RUN;
              busy_q  <= 1'b0;
            end else begin
              state_q <= FLUSH_EMIT;
            end
          end
        end
        FLUSH_EMIT: begin
          if (out_free) begin
            state_q <= RUN;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= RUN;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign OUT_DATA   = out_data_q;
  assign OUT_NBYTES = out_nb_q;
  assign OUT_VALID  = out_valid_q;
  assign BUSY       = busy_q;

endmodule
